// File: rtl/det_ctrl_pkg.sv
// Shared definitions for the "011" detector frame controller.
//   W_DEF   : default frame word width (maximum bits per frame)
//   CW_DEF  : default width of length/count/position fields (2^CW_DEF > W_DEF)
//   state_t : controller FSM encoding
package det_ctrl_pkg;

  localparam int W_DEF  = 16;
  localparam int CW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/det_frame_shreg.sv
// W-bit parallel-load, shift-left register feeding the serial detector.
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   load    : load din (takes priority over shift)
//   shift   : shift left by one, zero fill
//   din     : parallel frame word
//   msb     : current bit W-1
//   nxt_msb : bit that becomes the MSB after the next shift
module det_frame_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb,
  output logic         nxt_msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

  assign msb     = sr[W-1];
  assign nxt_msb = sr[W-2];

endmodule

// File: rtl/det_frame_ctrl.sv
// Frame-level sequencer for a serial "011" Mealy detector.
// A frame word and bit length are accepted on start, the detector is released
// from reset only while the frame is being shifted MSB-first, and the
// detector's match output is sampled every shift cycle.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   start              : frame request (only looked at in IDLE)
//   abort              : cancel frame (only looked at outside IDLE)
//   frame, len         : frame bits (bit W-1 first) and number of bits (1..W)
//   det_rst_n, det_din : active-low reset and serial data to the detector
//   det_dout           : detector match output, same cycle as det_din
//   busy, done, err    : status; done is a one-cycle pulse, err flags bad len
//   match_cnt          : matches seen in the last frame
//   first_pos/first_vld: 0-based index of the first match and its valid flag
// Handshake: start is a request that is accepted on any edge where the FSM is
// in IDLE; there is no ready output, so requests outside IDLE are dropped.
module det_frame_ctrl
  import det_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  frame,
  input  logic [CW-1:0] len,
  output logic          det_rst_n,
  output logic          det_din,
  input  logic          det_dout,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] first_pos,
  output logic          first_vld
);

  localparam logic [CW-1:0] W_MAX = CW'(W);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t        state;
  logic [CW-1:0] len_q;
  logic [CW-1:0] idx;
  logic          sh_load;
  logic          sh_shift;
  logic          sh_msb;
  logic          sh_nxt;
  logic          bad_len;
  logic          last_bit;

  // The frame is captured when start is accepted, so during LOAD the register
  // already presents frame[W-1] for the first registered det_din.
  assign sh_load  = (state == IDLE) && start;
  assign sh_shift = (state == SHIFT);
  assign bad_len  = (len_q == '0) || (len_q > W_MAX);
  assign last_bit = (idx == len_q - ONE);

  det_frame_shreg #(.W(W)) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (sh_load),
    .shift   (sh_shift),
    .din     (frame),
    .msb     (sh_msb),
    .nxt_msb (sh_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      idx       <= '0;
      det_rst_n <= 1'b0;
      det_din   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      match_cnt <= '0;
      first_pos <= '0;
      first_vld <= 1'b0;
    end else if (state != IDLE && abort) begin
      // Results keep their partial values; the bit in flight is not counted.
      state     <= IDLE;
      det_rst_n <= 1'b0;
      det_din   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            len_q <= len;
          end
        end
        LOAD: begin
          match_cnt <= '0;
          first_pos <= '0;
          first_vld <= 1'b0;
          idx       <= '0;
          if (bad_len) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            err       <= 1'b0;
            state     <= SHIFT;
            det_rst_n <= 1'b1;
            det_din   <= sh_msb;
          end
        end
        SHIFT: begin
          if (det_dout) begin
            match_cnt <= match_cnt + ONE;
            if (!first_vld) begin
              first_pos <= idx;
              first_vld <= 1'b1;
            end
          end
          idx <= idx + ONE;
          if (last_bit) begin
            state     <= DONE;
            done      <= 1'b1;
            det_rst_n <= 1'b0;
            det_din   <= 1'b0;
          end else begin
            det_din <= sh_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
